// File: rtl/motor_router.sv
// motor_router: crossbar from NUM_SRC step/dir/hold generators onto NUM_OUT driver
// outputs, with dir-to-step setup, fixed step pulse width and shadowed reconfiguration.
module motor_router #(
  parameter int NUM_SRC   = 8,
  parameter int NUM_OUT   = 4,
  parameter int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int CH_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  parameter int DIR_SETUP = 4,
  parameter int STEP_LEN  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] steps,
  input  logic [NUM_SRC-1:0] dirs,
  input  logic [NUM_SRC-1:0] holds,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_invert,
  input  logic               cfg_enable,
  input  logic               err_clr,
  output logic [NUM_OUT-1:0] step,
  output logic [NUM_OUT-1:0] dir,
  output logic [NUM_OUT-1:0] hold,
  output logic [NUM_OUT-1:0] cfg_pending,
  output logic [NUM_OUT-1:0] missed
);

  localparam int CNT_MAX = (DIR_SETUP > STEP_LEN) ? DIR_SETUP : STEP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE} state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

      logic [SEL_W-1:0] sel_reg, sel_next, shd_sel_reg, shd_sel_next;
      logic             invert_reg, invert_next, shd_invert_reg, shd_invert_next;
      logic             enable_reg, enable_next, shd_enable_reg, shd_enable_next;
      logic             pending_reg, pending_next;
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             queued_reg, queued_next;
      logic             prev_reg, prev_next;
      logic             step_reg, step_next;
      logic             dir_reg, dir_next;
      logic             hold_reg, hold_next;
      logic             missed_reg, missed_next;
      logic             miss_set, apply, src_edge, eff_dir, wr_hit;

      assign src_edge = steps[sel_reg] & ~prev_reg;
      assign eff_dir  = dirs[sel_reg] ^ invert_reg;
      assign wr_hit   = cfg_wr && (cfg_ch == CH_IDX);
      // Disables bypass the idle wait so a running pulse can be aborted.
      assign apply    = pending_reg &&
                        (((state_reg == ST_IDLE) && !queued_reg) || !shd_enable_reg);

      always_comb begin
        sel_next        = sel_reg;
        invert_next     = invert_reg;
        enable_next     = enable_reg;
        shd_sel_next    = shd_sel_reg;
        shd_invert_next = shd_invert_reg;
        shd_enable_next = shd_enable_reg;
        pending_next    = pending_reg;
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        queued_next     = queued_reg;
        prev_next       = steps[sel_reg];
        step_next       = step_reg;
        dir_next        = dir_reg;
        hold_next       = holds[sel_reg] & enable_reg;
        miss_set        = 1'b0;

        if (apply) begin
          sel_next     = shd_sel_reg;
          invert_next  = shd_invert_reg;
          enable_next  = shd_enable_reg;
          pending_next = 1'b0;
          // Sample the new source so switching never fabricates an edge.
          prev_next    = steps[shd_sel_reg];
          if (!shd_enable_reg) begin
            step_next   = 1'b0;
            hold_next   = 1'b0;
            state_next  = ST_IDLE;
            queued_next = 1'b0;
            cnt_next    = '0;
          end
        end else if (!enable_reg) begin
          step_next   = 1'b0;
          hold_next   = 1'b0;
          state_next  = ST_IDLE;
          queued_next = 1'b0;
          cnt_next    = '0;
          dir_next    = eff_dir;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (eff_dir != dir_reg) begin
                dir_next   = eff_dir;
                cnt_next   = CNT_W'(DIR_SETUP);
                state_next = ST_SETUP;
                if (src_edge) begin
                  queued_next = 1'b1;
                  miss_set    = queued_reg;
                end
              end else if (src_edge || queued_reg) begin
                step_next   = 1'b1;
                cnt_next    = CNT_W'(STEP_LEN);
                state_next  = ST_PULSE;
                queued_next = 1'b0;
                miss_set    = src_edge && queued_reg;
              end
            end
            ST_SETUP: begin
              if (cnt_reg <= CNT_W'(1)) begin
                cnt_next = '0;
                if (src_edge || queued_reg) begin
                  step_next   = 1'b1;
                  cnt_next    = CNT_W'(STEP_LEN);
                  state_next  = ST_PULSE;
                  queued_next = 1'b0;
                  miss_set    = src_edge && queued_reg;
                end else begin
                  state_next = ST_IDLE;
                end
              end else begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (src_edge) begin
                  queued_next = 1'b1;
                  miss_set    = queued_reg;
                end
              end
            end
            ST_PULSE: begin
              if (src_edge) begin
                queued_next = 1'b1;
                miss_set    = queued_reg;
              end
              if (cnt_reg <= CNT_W'(1)) begin
                step_next  = 1'b0;
                state_next = ST_IDLE;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg - CNT_W'(1);
              end
            end
            default: state_next = ST_IDLE;
          endcase
        end

        if (wr_hit) begin
          shd_sel_next    = cfg_sel;
          shd_invert_next = cfg_invert;
          shd_enable_next = cfg_enable;
          pending_next    = 1'b1;
        end

        missed_next = (missed_reg & ~err_clr) | miss_set;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sel_reg        <= '0;
          invert_reg     <= 1'b0;
          enable_reg     <= 1'b0;
          shd_sel_reg    <= '0;
          shd_invert_reg <= 1'b0;
          shd_enable_reg <= 1'b0;
          pending_reg    <= 1'b0;
          state_reg      <= ST_IDLE;
          cnt_reg        <= '0;
          queued_reg     <= 1'b0;
          prev_reg       <= 1'b0;
          step_reg       <= 1'b0;
          dir_reg        <= 1'b0;
          hold_reg       <= 1'b0;
          missed_reg     <= 1'b0;
        end else begin
          sel_reg        <= sel_next;
          invert_reg     <= invert_next;
          enable_reg     <= enable_next;
          shd_sel_reg    <= shd_sel_next;
          shd_invert_reg <= shd_invert_next;
          shd_enable_reg <= shd_enable_next;
          pending_reg    <= pending_next;
          state_reg      <= state_next;
          cnt_reg        <= cnt_next;
          queued_reg     <= queued_next;
          prev_reg       <= prev_next;
          step_reg       <= step_next;
          dir_reg        <= dir_next;
          hold_reg       <= hold_next;
          missed_reg     <= missed_next;
        end
      end

      assign step[gi]        = step_reg;
      assign dir[gi]         = dir_reg;
      assign hold[gi]        = hold_reg;
      assign cfg_pending[gi] = pending_reg;
      assign missed[gi]      = missed_reg;
    end
  endgenerate

endmodule

// File: doc/motor_router.md
Name: motor_router

Overview:
- Parametrised crossbar: routes any of NUM_SRC step/dir/hold generator channels onto any of NUM_OUT physical driver outputs.
- Adds per-output dir-to-step setup timing, minimum step pulse width and glitch-free reconfiguration to source selection.
- Sits between the step generators and the driver pins; configured over a simple register-write strobe.

Parameters:
- NUM_SRC, 8, number of generator source channels.
- NUM_OUT, 4, number of physical motor outputs.
- SEL_W, $clog2(NUM_SRC), source select width.
- CH_W, $clog2(NUM_OUT) (min 1), output channel index width.
- DIR_SETUP, 4, cycles dir must be stable before a step rises (>=1).
- STEP_LEN, 8, step pulse high time in cycles (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- steps  in  NUM_SRC  source step levels, synchronous to clk.
- dirs  in  NUM_SRC  source directions.
- holds  in  NUM_SRC  source hold/enable requests.
- cfg_wr  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  output channel addressed by cfg_wr.
- cfg_sel  in  SEL_W  new source for cfg_ch.
- cfg_invert  in  1  new dir inversion for cfg_ch.
- cfg_enable  in  1  new enable for cfg_ch.
- err_clr  in  1  clears all missed flags.
- step  out  NUM_OUT  registered step outputs.
- dir  out  NUM_OUT  registered dir outputs.
- hold  out  NUM_OUT  registered hold outputs.
- cfg_pending  out  NUM_OUT  shadow config written, not yet applied.
- missed  out  NUM_OUT  sticky: a source step edge was dropped.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n; all state clears immediately on assertion.
- Reset values: step, dir, hold, cfg_pending, missed = 0. Every channel: sel=0, invert=0, enable=0, FSM=IDLE, queued=0, counters=0, prev_step=0.
- Per-output FSM states: IDLE, SETUP, PULSE.
- Effective signals: eff_dir = dirs[sel]^invert; edge = steps[sel] & ~prev_step. prev_step updates every cycle.
- IDLE:
  - If eff_dir != dir: load dir, counter=DIR_SETUP, go SETUP. A coincident edge sets queued.
  - Else if edge: step=1, counter=STEP_LEN, go PULSE. Step is high the cycle after the edge is first sampled (1-cycle latency).
- SETUP:
  - dir is held; counter decrements.
  - An edge sets queued. An edge while queued is already 1 sets missed.
  - On counter reaching 0: if queued, clear queued, step=1, go PULSE; else go IDLE.
- PULSE:
  - step held high for exactly STEP_LEN cycles, then step=0, go IDLE.
  - dir is frozen; a source dir change is deferred and handled in IDLE.
  - An edge during PULSE sets queued. If queued is already 1, set missed.
  - On exit with queued=1: handle via IDLE rules next cycle, including any pending dir change; queued then starts a pulse.
- Step spacing: at least 1 low cycle between pulses.
- hold output: holds[sel] & enable, registered, 1-cycle latency.
- Enable low:
  - step=0 and hold=0, FSM forced IDLE, queued cleared, no missed set.
  - dir still tracks eff_dir, 1-cycle latency, no setup timing.
- Config writes:
  - cfg_wr stores sel/invert/enable into the shadow for cfg_ch and sets cfg_pending[cfg_ch].
  - A second write before apply overwrites the shadow.
  - cfg_ch >= NUM_OUT is ignored.
  - Apply happens in the first cycle the channel is IDLE with queued=0, including the write cycle+1 if already idle. On apply: clear cfg_pending, and load prev_step from steps[new sel] so a source switch never creates a false edge.
  - A disable (enable 0) applies immediately regardless of state, aborting any pulse: step drops next cycle.
- missed: sticky until err_clr. err_clr and a coincident new miss in the same cycle leaves the flag set.
- Channels are independent. Several outputs may select the same source.

Test Plan:
- Reset, then cfg ch0 sel=3 enable=1; pulse steps[3] for 1 cycle -> step[0] high 8 cycles starting 1 cycle later; dir[0]=dirs[3]; cfg_pending[0] pulses for 1 cycle.
- On ch0, flip dirs[3] and raise steps[3] in the same cycle -> dir[0] toggles next cycle; step[0] rises exactly 4 cycles after dir[0] toggles; no missed.
- Three step edges 2 cycles apart on ch0 during a pulse -> second is queued and emitted after a 1-cycle low gap; third sets missed[0]; err_clr clears it.
- Rewrite ch1 sel 2->5 mid-pulse while steps[5]=1 is held -> cfg_pending[1] stays high until pulse end; no spurious step after the switch.
- cfg_invert=1 on ch2 -> dir[2]=~dirs[sel]. Then cfg_enable=0 mid-pulse -> step[2] and hold[2] drop next cycle; dir still tracks.
- Assert rst_n=0 mid-SETUP on ch0 -> all outputs 0 immediately; after release, ch0 is disabled and sel=0.
